// File: rtl/register_pipe.sv
//------------------------------------------------------------------------------
// Module      : register_pipe
// Description : Elastic pipeline register. STAGES slots of WIDTH bits, each
//               with its own valid bit. Bubbles collapse: a stage accepts new
//               data whenever it is empty or the stage ahead of it is moving.
//               Supports synchronous flush, a programmable reset value for
//               the data registers, and a registered occupancy count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module register_pipe #(
   parameter int               WIDTH       = 8,
   parameter int               STAGES      = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WIDTH-1:0]                in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH-1:0]                out_data,
   output logic [$clog2(STAGES+1)-1:0]     occupancy
);

   localparam int C_OCC_W = $clog2(STAGES + 1);

   // Stage state: index 0 is the input side, STAGES-1 drives the output.
   logic [STAGES-1:0]  vld_q;
   logic [STAGES-1:0]  vld_d;
   logic [WIDTH-1:0]   dat_q [STAGES];
   logic [WIDTH-1:0]   dat_d [STAGES];
   logic [C_OCC_W-1:0] occ_q;
   logic [C_OCC_W-1:0] occ_d;

   // rdy[i] means stage i may load this cycle; rdy[STAGES] is the sink.
   logic [STAGES:0]    rdy;
   // Value offered to each stage by its upstream neighbour (or the input port).
   logic [STAGES-1:0]  src_vld;
   logic [WIDTH-1:0]   src_dat [STAGES];

   // Ready ripples back from the sink: an empty stage is always free to load,
   // which is what lets bubbles collapse while the output is stalled.
   always_comb begin
      rdy[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         rdy[i] = ~vld_q[i] | rdy[i+1];
      end
   end

   // Reset overrides flush so the port advertises ready while rst_n is low;
   // anything offered then is discarded by the reset branch below.
   assign in_ready = ~rst_n | (rdy[0] & ~flush);

   // Source of each stage: the input port for stage 0, the previous stage otherwise.
   always_comb begin
      src_vld[0] = in_valid & ~flush;
      src_dat[0] = in_data;
      for (int i = 1; i < STAGES; i++) begin
         src_vld[i] = vld_q[i-1];
         src_dat[i] = dat_q[i-1];
      end
   end

   // Next-state: advance ready stages, hold stalled ones, flush wins over moves.
   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      for (int i = 0; i < STAGES; i++) begin
         if (rdy[i]) begin
            vld_d[i] = src_vld[i];
            // Data only loads with a valid item; an empty slot keeps stale data.
            if (src_vld[i]) begin
               dat_d[i] = src_dat[i];
            end
         end
      end
      if (flush) begin
         vld_d = '0;
         for (int i = 0; i < STAGES; i++) begin
            dat_d[i] = RESET_VALUE;
         end
      end
   end

   // Occupancy is the population count of the next-state valid vector so the
   // registered value lines up with the valid bits it describes.
   always_comb begin
      occ_d = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ_d = occ_d + C_OCC_W'(vld_d[i]);
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         occ_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            dat_q[i] <= RESET_VALUE;
         end
      end else begin
         vld_q <= vld_d;
         occ_q <= occ_d;
         dat_q <= dat_d;
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign out_data  = dat_q[STAGES-1];
   assign occupancy = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_register_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_register_pipe
// Description : Self-checking bench for register_pipe (WIDTH=8, STAGES=3,
//               RESET_VALUE=8'hA5). Accepted items are queued as expected
//               outputs and compared in order when the pipe emits them.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_register_pipe;

   localparam int         C_WIDTH  = 8;
   localparam int         C_STAGES = 3;
   localparam logic [7:0] C_RST    = 8'hA5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] occupancy;

   int         pass_cnt  = 0;
   int         total_cnt = 0;
   int         cyc       = 0;
   logic [7:0] exp_q [$];

   register_pipe #(
      .WIDTH       (C_WIDTH),
      .STAGES      (C_STAGES),
      .RESET_VALUE (C_RST)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // One clock: settle inputs, update the scoreboard for this edge, advance.
   task automatic tick();
      logic [7:0] exp_v;
      #1;
      if (!rst_n || flush) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_unexpected: got %02h, no item expected", out_data);
            end else begin
               exp_v = exp_q.pop_front();
               if (out_data !== exp_v) $display("FAIL sb_data: got %02h want %02h", out_data, exp_v);
               else pass_cnt++;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(in_data);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'hEE;
      tick(); tick();
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready_held: got %0b want 1", in_ready);
      else pass_cnt++;
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid);
      else pass_cnt++;
      total_cnt++;
      if (out_data !== C_RST) $display("FAIL reset_out_data: got %02h want %02h", out_data, C_RST);
      else pass_cnt++;
      total_cnt++;
      if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy);
      else pass_cnt++;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_streaming();
      int acc_cyc   = -1;
      int first_out = -1;
      out_ready = 1'b1;
      for (int v = 1; v <= 16; v++) begin
         in_valid = 1'b1; in_data = 8'(v);
         #1;
         if (out_valid && first_out < 0) first_out = cyc;
         total_cnt++;
         if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %0b want 1", v, in_ready);
         else pass_cnt++;
         if (v >= 4) begin
            total_cnt++;
            if (occupancy !== 2'd3 || out_valid !== 1'b1)
               $display("FAIL stream_steady[%0d]: occ %0d valid %0b want occ 3 valid 1", v, occupancy, out_valid);
            else pass_cnt++;
         end
         if (v == 1) acc_cyc = cyc;
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
      total_cnt++;
      if (first_out - acc_cyc !== 3) $display("FAIL stream_latency: got %0d want 3", first_out - acc_cyc);
      else pass_cnt++;
      total_cnt++;
      if (exp_q.size() != 0 || occupancy !== 2'd0)
         $display("FAIL stream_drain: left %0d occ %0d want 0 0", exp_q.size(), occupancy);
      else pass_cnt++;
   endtask

   task automatic test_stall_fill();
      logic [7:0] items [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = items[k];
         #1;
         total_cnt++;
         if (in_ready !== 1'b1) $display("FAIL stall_accept[%0d]: got %0b want 1", k, in_ready);
         else pass_cnt++;
         tick();
      end
      in_data = items[3];
      for (int k = 0; k < 2; k++) begin
         #1;
         total_cnt++;
         if (in_ready !== 1'b0 || occupancy !== 2'd3 || out_valid !== 1'b1 || out_data !== 8'h11)
            $display("FAIL stall_full[%0d]: rdy %0b occ %0d vld %0b data %02h want 0 3 1 11",
                     k, in_ready, occupancy, out_valid, out_data);
         else pass_cnt++;
         tick();
      end
      out_ready = 1'b1;
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL stall_passthru_ready: got %0b want 1", in_ready);
      else pass_cnt++;
      tick();
      out_ready = 1'b0; in_valid = 1'b0;
      #1;
      total_cnt++;
      if (occupancy !== 2'd3 || out_data !== 8'h22)
         $display("FAIL stall_swap: occ %0d data %02h want 3 22", occupancy, out_data);
      else pass_cnt++;
      out_ready = 1'b1;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL stall_drain: left %0d want 0", exp_q.size());
      else pass_cnt++;
      tick();
   endtask

   task automatic test_bubble_collapse();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h55; tick();
      in_valid = 1'b0; tick(); tick();
      in_valid = 1'b1; in_data = 8'h66; tick();
      in_valid = 1'b0; tick();
      #1;
      total_cnt++;
      if (occupancy !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'h55)
         $display("FAIL bubble_packed: occ %0d vld %0b data %02h want 2 1 55", occupancy, out_valid, out_data);
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 8'h66)
         $display("FAIL bubble_consecutive: vld %0b data %02h want 1 66", out_valid, out_data);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid !== 1'b0 || exp_q.size() != 0)
         $display("FAIL bubble_empty: vld %0b left %0d want 0 0", out_valid, exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_flush();
      int seen = 0;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = 8'h81 + 8'(k); tick();
      end
      flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
      #1;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %0b want 0", in_ready);
      else pass_cnt++;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      total_cnt++;
      if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== C_RST)
         $display("FAIL flush_cleared: occ %0d vld %0b data %02h want 0 0 a5", occupancy, out_valid, out_data);
      else pass_cnt++;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (out_valid) seen++;
         tick();
      end
      total_cnt++;
      if (seen != 0) $display("FAIL flush_dropped: got %0d outputs want 0", seen);
      else pass_cnt++;
   endtask

   task automatic test_reset_midstream();
      int acc_cyc = -1;
      int out_cyc = -1;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h91; tick();
      in_data = 8'h92; tick();
      rst_n = 1'b0; flush = 1'b1; in_data = 8'hEE;
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %0b want 1", in_ready);
      else pass_cnt++;
      tick();
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
      #1;
      total_cnt++;
      if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== C_RST)
         $display("FAIL midrst_cleared: occ %0d vld %0b data %02h want 0 0 a5", occupancy, out_valid, out_data);
      else pass_cnt++;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h99;
      acc_cyc = cyc;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 10 && out_cyc < 0; k++) begin
         #1;
         if (out_valid) out_cyc = cyc;
         else tick();
      end
      total_cnt++;
      if (out_cyc - acc_cyc !== 3 || out_data !== 8'h99)
         $display("FAIL midrst_latency: got %0d data %02h want 3 99", out_cyc - acc_cyc, out_data);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL midrst_drain: left %0d want 0", exp_q.size());
      else pass_cnt++;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_streaming();
      test_stall_fill();
      test_bubble_collapse();
      test_flush();
      test_reset_midstream();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/register_pipe.md
Name: register_pipe

Overview:
- Parametrised, elastic pipeline register: a chain of STAGES registers of WIDTH bits, each with a valid bit and a valid/ready handshake.
- Bubbles collapse, so a stalled output never blocks an upstream stage while an empty slot exists downstream.
- Adds a synchronous flush, a programmable reset value and an occupancy count.
- General-purpose timing-closure and retiming element between streaming blocks.

Parameters:
- WIDTH, 8, data width in bits; legal values ≥1.
- STAGES, 2, number of register stages; legal values ≥1.
- RESET_VALUE, '0, WIDTH-bit value loaded into every data register on reset and flush.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- flush  input  1  synchronous clear of all stages; active-high.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block accepts data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  output data valid.
- out_ready  input  1  downstream accepts data this cycle.
- out_data  output  WIDTH  output data.
- occupancy  output  $clog2(STAGES+1)  number of stages currently holding valid data.

Behaviour:
- State: stages 0 (input side) to STAGES-1 (output side). Each stage i has vld[i] and dat[i].
- Reset (rst_n=0 at a clock edge):
  - vld[*]=0 and dat[*]=RESET_VALUE.
  - Consequently out_valid=0, out_data=RESET_VALUE, occupancy=0.
  - in_ready is 1 combinationally while reset is held, but no transfer occurs and input is ignored.
- Reset priority: reset has priority over flush, and flush has priority over any transfer.
- Flush (flush=1, rst_n=1):
  - Next cycle: vld[*]=0 and dat[*]=RESET_VALUE.
  - The in_valid/in_ready handshake in the flush cycle is discarded; the item is dropped, not stored.
  - in_ready is forced to 0 during flush.
- Ready chain (combinational):
  - rdy[STAGES]=out_ready.
  - rdy[i] = !vld[i] | rdy[i+1].
  - in_ready = rdy[0] & !flush.
  - The path from out_ready to in_ready is combinational by design; there is no skid buffer.
- Advance, each clock edge, for each stage i with rdy[i]=1:
  - vld[i] <= src_valid, where src_valid = in_valid & !flush for i=0, else vld[i-1].
  - dat[i] <= src_data only when src_valid=1.
  - When src_valid=0, dat[i] holds; stale data remains, but its valid bit is 0.
- Hold: a stage with rdy[i]=0 holds both vld and dat unchanged.
- Outputs:
  - out_valid = vld[STAGES-1] and out_data = dat[STAGES-1], driven directly from registers.
  - occupancy = population count of vld, registered (derived from next-state vld).
- Handshake rules:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - Upstream must hold in_valid/in_data stable until accepted. The block guarantees out_valid/out_data stay stable while out_valid & !out_ready.
- Latency and throughput:
  - An item accepted into an empty pipe appears at out_valid exactly STAGES cycles later.
  - Sustained throughput is 1 item/cycle with out_ready held at 1.
  - No item is ever dropped or duplicated (flush excepted), and ordering is FIFO.
- Capacity and boundaries:
  - Maximum occupancy is STAGES.
  - Full with out_ready=0 gives in_ready=0.
  - Full with out_ready=1 gives in_ready=1: simultaneous in and out are accepted and occupancy is unchanged.
  - An empty stage between valid stages is filled on the next edge even when out_ready=0 (bubble collapse).
- Reset mid-stream: all in-flight items are lost and there is no partial state. The first handshake is legal in the cycle after rst_n returns high.
- STAGES=1: degenerates to a single registered slot with a combinational ready pass-through.

Test Plan (WIDTH=8, STAGES=3, RESET_VALUE=8'hA5 unless stated):
1. Reset then idle, no inputs -> out_valid=0, out_data=8'hA5, occupancy=0, in_ready=1 after rst_n=1.
2. Streaming:
   - Stimulus: out_ready=1; send 8'h01..8'h10 back-to-back.
   - Required: 8'h01 appears 3 cycles after acceptance; one item per cycle, in order.
   - Required: occupancy=3 in steady state, in_ready never drops.
3. Stall and fill:
   - Stimulus: out_ready=0; send 8'h11, 8'h22, 8'h33, 8'h44.
   - Required: first three are accepted and the 4th is stalled with in_ready=0.
   - Required: occupancy=3, and out_data holds 8'h11 stable.
   - Stimulus: raise out_ready for 1 cycle.
   - Required: 8'h11 leaves, 8'h44 is accepted in the same cycle, occupancy stays 3.
4. Bubble collapse:
   - Stimulus: out_ready=0; send 8'h55, idle 2 cycles, send 8'h66.
   - Required: 8'h55 reaches stage 2 and 8'h66 is packed into stage 1 with no gap.
   - Stimulus: release out_ready.
   - Required: 8'h55 then 8'h66 on consecutive cycles.
5. Flush:
   - Stimulus: 3 items in flight; assert flush together with in_valid=1, in_data=8'h77.
   - Required: next cycle occupancy=0, out_valid=0, out_data=8'hA5.
   - Required: 8'h77 is never output, and in_ready=0 during the flush cycle.
6. Reset mid-stream: 2 items in flight, pulse rst_n=0 for 1 cycle with flush=1 -> all stages cleared, occupancy=0, subsequent item 8'h99 emerges after exactly 3 cycles.
